// File: rtl/fd_pipe_reg_if.sv
// fd_pipe_reg_if: Fetch-to-Decode bundle for the F/D pipeline register.
//
// Groups the hazard controls (stall, flush), the fetch-side inputs (F_PC,
// F_instruction, F_bd) and the decode-side outputs (D_PC, D_instruction,
// D_PC8, D_bd, D_valid, D_exccode) plus the stall/flush counters.
//
// Modports:
//   slave  - the pipeline register: takes controls and F_*, drives D_* and counters.
//   master - the surrounding pipeline (or a bench): drives controls and F_*, observes D_*.
interface fd_pipe_reg_if;
  logic        stall;
  logic        flush;
  logic [31:0] F_PC;
  logic [31:0] F_instruction;
  logic        F_bd;
  logic [31:0] D_PC;
  logic [31:0] D_instruction;
  logic [31:0] D_PC8;
  logic        D_bd;
  logic        D_valid;
  logic [4:0]  D_exccode;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  modport slave (
    input  stall, flush, F_PC, F_instruction, F_bd,
    output D_PC, D_instruction, D_PC8, D_bd, D_valid, D_exccode, stall_cnt, flush_cnt
  );

  modport master (
    output stall, flush, F_PC, F_instruction, F_bd,
    input  D_PC, D_instruction, D_PC8, D_bd, D_valid, D_exccode, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/fd_pipe_reg.sv
// fd_pipe_reg: F/D pipeline register.
//
// Captures the fetched PC/instruction pair every cycle and presents it to
// Decode one cycle later. Priority on each rising edge is flush > stall >
// load. A flush writes a bubble (valid=0, nop, no exception) that still
// carries F_PC/F_bd so EPC can be formed from it. A fetch from a misaligned
// or out-of-range address loads a nop tagged with ADEL_CODE and keeps the
// faulting PC.
//
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous, active-low reset
//   bus    - fd_pipe_reg_if.slave: stall/flush, F_* inputs, D_* outputs,
//            stall_cnt/flush_cnt
//
// Build option: define FD_PERF_CNT_EN to enable the saturating 16-bit
// stall/flush cycle counters; otherwise both read as zero and no counter
// flops are built.
module fd_pipe_reg #(
  parameter logic [31:0] PC_RESET  = 32'h0000_3000,
  parameter logic [31:0] IM_BASE   = 32'h0000_3000,
  parameter int unsigned IM_WORDS  = 4096,
  parameter logic [4:0]  ADEL_CODE = 5'd4
) (
  input logic          clk,
  input logic          reset,
  fd_pipe_reg_if.slave bus
);

  // Exclusive upper bound of instruction memory, 33 bits wide so it cannot wrap.
  localparam logic [32:0] ImLimit = {1'b0, IM_BASE} + (33'(IM_WORDS) << 2);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        bd_q, bd_d;
  logic        valid_q, valid_d;
  logic [4:0]  exc_q, exc_d;

  logic fetch_fault;

  // Fetch address check on the raw F_PC, unsigned compare.
  always_comb begin
    fetch_fault = 1'b0;
    if (bus.F_PC[1:0] != 2'b00) begin
      fetch_fault = 1'b1;
    end
    if (bus.F_PC < IM_BASE) begin
      fetch_fault = 1'b1;
    end
    if ({1'b0, bus.F_PC} >= ImLimit) begin
      fetch_fault = 1'b1;
    end
  end

  // Next state: default is hold, which covers the stall case.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    bd_d    = bd_q;
    valid_d = valid_q;
    exc_d   = exc_q;
    if (bus.flush) begin
      // Bubble still carries the fetch PC and delay-slot flag.
      pc_d    = bus.F_PC;
      bd_d    = bus.F_bd;
      instr_d = 32'h0;
      valid_d = 1'b0;
      exc_d   = 5'd0;
    end else if (!bus.stall) begin
      pc_d    = bus.F_PC;
      bd_d    = bus.F_bd;
      valid_d = 1'b1;
      if (fetch_fault) begin
        instr_d = 32'h0;
        exc_d   = ADEL_CODE;
      end else begin
        instr_d = bus.F_instruction;
        exc_d   = 5'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= PC_RESET;
      instr_q <= 32'h0;
      bd_q    <= 1'b0;
      valid_q <= 1'b0;
      exc_q   <= 5'd0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      bd_q    <= bd_d;
      valid_q <= valid_d;
      exc_q   <= exc_d;
    end
  end

  assign bus.D_PC          = pc_q;
  assign bus.D_instruction = instr_q;
  assign bus.D_bd          = bd_q;
  assign bus.D_valid       = valid_q;
  assign bus.D_exccode     = exc_q;
  // Link address for jal/jalr; wraps modulo 2^32.
  assign bus.D_PC8         = pc_q + 32'd8;

`ifdef FD_PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  // Saturating counters: a stall under flush counts as a flush only.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.flush) begin
      if (flush_cnt_q != 16'hFFFF) begin
        flush_cnt_d = flush_cnt_q + 16'd1;
      end
    end else if (bus.stall) begin
      if (stall_cnt_q != 16'hFFFF) begin
        stall_cnt_d = stall_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= 16'h0;
      flush_cnt_q <= 16'h0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`else
  assign bus.stall_cnt = 16'h0;
  assign bus.flush_cnt = 16'h0;
`endif

endmodule
